// File: rtl/ads127l1x_frame_sequencer.sv
// Snapshots one TDM frame of ADS127L1x packets and splits each packet into fields.
// It checks the CRC-8 and streams one tagged word per channel through a fall-through FIFO.
module ads127l1x_frame_sequencer #(
    parameter int CHANNEL_COUNT = 8,
    parameter int STATUS_EN     = 1,
    parameter int DATA_BITS     = 24,
    parameter int CRC_EN        = 1,
    parameter int FIFO_DEPTH    = 16,
    localparam int BITS_PER_PACKET = 8*STATUS_EN + DATA_BITS + 8*CRC_EN
) (
    input  logic                       ADC_DCLK,
    input  logic                       RESET_N,
    input  logic                       data_ready,
    input  logic [BITS_PER_PACKET-1:0] ch0_packet,
    input  logic [BITS_PER_PACKET-1:0] ch1_packet,
    input  logic [BITS_PER_PACKET-1:0] ch2_packet,
    input  logic [BITS_PER_PACKET-1:0] ch3_packet,
    input  logic [BITS_PER_PACKET-1:0] ch4_packet,
    input  logic [BITS_PER_PACKET-1:0] ch5_packet,
    input  logic [BITS_PER_PACKET-1:0] ch6_packet,
    input  logic [BITS_PER_PACKET-1:0] ch7_packet,
    input  logic                       clear_flags,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [2:0]                 out_channel,
    output logic [7:0]                 out_status,
    output logic [31:0]                out_data,
    output logic                       out_crc_err,
    output logic                       fifo_overflow,
    output logic                       frame_overrun,
    output logic [15:0]                dropped_count
);

    localparam int MSG_BITS = 8*STATUS_EN + DATA_BITS;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;
    localparam logic [2:0]  LAST_IDX   = 3'(CHANNEL_COUNT - 1);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(FIFO_DEPTH);

    logic [BITS_PER_PACKET-1:0] w_ch [0:7];
    logic [BITS_PER_PACKET-1:0] r_snap [0:7];
    logic [43:0]                r_mem [0:FIFO_DEPTH-1];

    logic           r_dr_q;
    logic [0:0]     r_state;
    logic [2:0]     r_idx;
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_count;
    logic           r_fifo_overflow;
    logic           r_frame_overrun;
    logic [15:0]    r_dropped_count;

    logic                       w_frame_start;
    logic                       w_snap_load;
    logic                       w_overrun_evt;
    logic [BITS_PER_PACKET-1:0] w_pkt;
    logic [7:0]                 w_status;
    logic [DATA_BITS-1:0]       w_data_raw;
    logic [MSG_BITS-1:0]        w_msg;
    logic                       w_crc_err;
    logic [31:0]                w_data_ext;
    logic [43:0]                w_word;
    logic [43:0]                w_head;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_full;
    logic                       w_wr_en;
    logic                       w_drop;

    assign w_ch[0] = ch0_packet;
    assign w_ch[1] = ch1_packet;
    assign w_ch[2] = ch2_packet;
    assign w_ch[3] = ch3_packet;
    assign w_ch[4] = ch4_packet;
    assign w_ch[5] = ch5_packet;
    assign w_ch[6] = ch6_packet;
    assign w_ch[7] = ch7_packet;

    function automatic logic [7:0] crc8_calc(input logic [MSG_BITS-1:0] msg);
        logic [7:0] crc;
        logic       fb;
        crc = 8'hFF;
        for (int i = MSG_BITS - 1; i >= 0; i--) begin
            fb  = crc[7] ^ msg[i];
            crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return crc;
    endfunction

    // dr_q resets high so a data_ready already high out of reset is not taken as a frame.
    assign w_frame_start = data_ready & ~r_dr_q;
    assign w_snap_load   = w_frame_start & (r_state == ST_IDLE);
    assign w_overrun_evt = w_frame_start & (r_state == ST_SEND);

    always_ff @(posedge ADC_DCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dr_q  <= 1'b1;
            r_state <= ST_IDLE;
            r_idx   <= 3'd0;
        end else begin
            r_dr_q <= data_ready;
            case (r_state)
                ST_IDLE: begin
                    if (w_frame_start) begin
                        r_state <= ST_SEND;
                        r_idx   <= 3'd0;
                    end
                end
                default: begin
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_IDLE;
                        r_idx   <= 3'd0;
                    end else begin
                        r_idx <= r_idx + 3'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge ADC_DCLK) begin
        if (w_snap_load) begin
            for (int i = 0; i < CHANNEL_COUNT; i++) begin
                r_snap[i] <= w_ch[i];
            end
        end
    end

    assign w_pkt      = r_snap[r_idx];
    assign w_data_raw = w_pkt[8*CRC_EN +: DATA_BITS];

    generate
        if (STATUS_EN != 0) begin : g_status
            assign w_status = w_pkt[BITS_PER_PACKET-1 -: 8];
        end else begin : g_no_status
            assign w_status = 8'h00;
        end
    endgenerate

    // With no status byte the truncation keeps only the data bits.
    assign w_msg = MSG_BITS'({w_status, w_data_raw});

    generate
        if (CRC_EN != 0) begin : g_crc
            assign w_crc_err = (crc8_calc(w_msg) != w_pkt[7:0]);
        end else begin : g_no_crc
            assign w_crc_err = 1'b0;
        end
    endgenerate

    assign w_data_ext = {{(32-DATA_BITS){w_data_raw[DATA_BITS-1]}}, w_data_raw};
    assign w_word     = {r_idx, w_crc_err, w_status, w_data_ext};

    assign out_valid = (r_count != '0);
    assign w_push    = (r_state == ST_SEND);
    assign w_pop     = out_valid & out_ready;
    assign w_full    = (r_count == FULL_COUNT);
    assign w_wr_en   = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    always_ff @(posedge ADC_DCLK) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= w_word;
        end
    end

    always_ff @(posedge ADC_DCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head fields read as zero while empty so stale RAM contents never leak out.
    assign w_head      = out_valid ? r_mem[r_rd_ptr] : 44'd0;
    assign out_channel = w_head[43:41];
    assign out_crc_err = w_head[40];
    assign out_status  = w_head[39:32];
    assign out_data    = w_head[31:0];

    always_ff @(posedge ADC_DCLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_fifo_overflow <= 1'b0;
            r_frame_overrun <= 1'b0;
            r_dropped_count <= 16'd0;
        end else begin
            if (w_drop) begin
                r_fifo_overflow <= 1'b1;
                if (clear_flags) begin
                    r_dropped_count <= 16'd1;
                end else if (r_dropped_count != 16'hFFFF) begin
                    r_dropped_count <= r_dropped_count + 16'd1;
                end
            end else if (clear_flags) begin
                r_fifo_overflow <= 1'b0;
                r_dropped_count <= 16'd0;
            end
            if (w_overrun_evt) begin
                r_frame_overrun <= 1'b1;
            end else if (clear_flags) begin
                r_frame_overrun <= 1'b0;
            end
        end
    end

    assign fifo_overflow = r_fifo_overflow;
    assign frame_overrun = r_frame_overrun;
    assign dropped_count = r_dropped_count;

endmodule

// File: tb/tb_ads127l1x_frame_sequencer.sv
// Scoreboard bench for ads127l1x_frame_sequencer: stimulus queues expected words,
// a monitor pops and compares every word the DUT hands over.
module tb_ads127l1x_frame_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        data_ready = 1'b0;
    logic        clear_flags = 1'b0;
    logic        out_ready = 1'b0;
    logic [39:0] pkt [0:7];
    logic        out_valid;
    logic [2:0]  out_channel;
    logic [7:0]  out_status;
    logic [31:0] out_data;
    logic        out_crc_err;
    logic        fifo_overflow;
    logic        frame_overrun;
    logic [15:0] dropped_count;

    logic [43:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    ads127l1x_frame_sequencer dut (
        .ADC_DCLK      (clk),
        .RESET_N       (rst_n),
        .data_ready    (data_ready),
        .ch0_packet    (pkt[0]),
        .ch1_packet    (pkt[1]),
        .ch2_packet    (pkt[2]),
        .ch3_packet    (pkt[3]),
        .ch4_packet    (pkt[4]),
        .ch5_packet    (pkt[5]),
        .ch6_packet    (pkt[6]),
        .ch7_packet    (pkt[7]),
        .clear_flags   (clear_flags),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_channel   (out_channel),
        .out_status    (out_status),
        .out_data      (out_data),
        .out_crc_err   (out_crc_err),
        .fifo_overflow (fifo_overflow),
        .frame_overrun (frame_overrun),
        .dropped_count (dropped_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [43:0] act, input logic [43:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", name, act, req);
    endtask

    function automatic logic [7:0] ref_crc(input logic [31:0] m);
        logic [7:0] c = 8'hFF;
        for (int i = 31; i >= 0; i--) begin
            if (c[7] ^ m[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else             c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    // Channel `special` carries data 0x800000 with a corrupted CRC byte.
    task automatic set_frame(input logic [7:0] sbase, input logic [23:0] dbase,
                             input int special, input bit expect_it);
        logic [7:0]  s;
        logic [23:0] d;
        bit          bad;
        for (int n = 0; n < 8; n++) begin
            bad = (n == special);
            s   = 8'(sbase + n);
            d   = bad ? 24'h800000 : 24'(dbase + n);
            pkt[n] = {s, d, ref_crc({s, d}) ^ (bad ? 8'h01 : 8'h00)};
            if (expect_it) exp_q.push_back({3'(n), bad, s, {{8{d[23]}}, d}});
        end
    endtask

    task automatic pulse_dr();
        @(negedge clk) data_ready = 1'b1;
        @(negedge clk) data_ready = 1'b0;
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear_flags = 1'b1;
        @(negedge clk) clear_flags = 1'b0;
    endtask

    always @(negedge clk) begin
        logic [43:0] act;
        logic [43:0] req;
        #2;
        if (rst_n && out_valid && out_ready) begin
            act = {out_channel, out_crc_err, out_status, out_data};
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_word: got %h required no word", act);
            end else begin
                req = exp_q.pop_front();
                check($sformatf("word_ch%0d", req[43:41]), act, req);
                $display("word ch=%0d status=%h data=%h crc_err=%0d", out_channel, out_status, out_data, out_crc_err);
            end
        end
    end

    initial begin
        for (int n = 0; n < 8; n++) pkt[n] = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid",    44'(out_valid),     44'd0);
        check("rst_channel",  44'(out_channel),   44'd0);
        check("rst_status",   44'(out_status),    44'd0);
        check("rst_data",     44'(out_data),      44'd0);
        check("rst_crc_err",  44'(out_crc_err),   44'd0);
        check("rst_overflow", 44'(fifo_overflow), 44'd0);
        check("rst_overrun",  44'(frame_overrun), 44'd0);
        check("rst_dropped",  44'(dropped_count), 44'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame: all eight words must leave on consecutive cycles.
        out_ready = 1'b1;
        set_frame(8'h80, 24'h000000, -1, 1'b1);
        pulse_dr();
        repeat (9) @(negedge clk);
        #3;
        check("t1_drained_valid", 44'(out_valid),    44'd0);
        check("t1_drained_queue", 44'(exp_q.size()), 44'd0);

        // Negative full-scale data with a bad CRC on channel 3.
        set_frame(8'h80, 24'h000100, 3, 1'b1);
        pulse_dr();
        repeat (12) @(negedge clk);
        check("t2_queue", 44'(exp_q.size()), 44'd0);

        // Consumer stalled across three frames: third frame is dropped.
        out_ready = 1'b0;
        set_frame(8'h10, 24'h001000, -1, 1'b1);
        pulse_dr();
        repeat (9) @(negedge clk);
        set_frame(8'h20, 24'h002000, -1, 1'b1);
        pulse_dr();
        repeat (9) @(negedge clk);
        set_frame(8'h30, 24'h003000, -1, 1'b0);
        pulse_dr();
        repeat (10) @(negedge clk);
        #1;
        check("t3_overflow",    44'(fifo_overflow), 44'd1);
        check("t3_dropped",     44'(dropped_count), 44'd8);
        check("t3_head_valid",  44'(out_valid),     44'd1);
        check("t3_head_chan",   44'(out_channel),   44'd0);
        check("t3_head_status", 44'(out_status),    44'h10);
        out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_queue", 44'(exp_q.size()), 44'd0);
        pulse_clear();
        #1;
        check("t3_clr_overflow", 44'(fifo_overflow), 44'd0);
        check("t3_clr_dropped",  44'(dropped_count), 44'd0);

        // Second data_ready edge three cycles into a frame.
        set_frame(8'h40, 24'h004000, -1, 1'b1);
        @(negedge clk) data_ready = 1'b1;
        @(negedge clk) data_ready = 1'b0;
        @(negedge clk);
        set_frame(8'h50, 24'h005000, -1, 1'b0);
        data_ready = 1'b1;
        @(negedge clk) data_ready = 1'b0;
        repeat (12) @(negedge clk);
        #1;
        check("t4_overrun", 44'(frame_overrun), 44'd1);
        check("t4_queue",   44'(exp_q.size()),  44'd0);
        pulse_clear();
        #1;
        check("t4_clr_overrun", 44'(frame_overrun), 44'd0);

        // data_ready held high through reset release must not start a frame.
        @(negedge clk);
        rst_n = 1'b0;
        data_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check("t5_no_words", 44'(out_valid), 44'd0);
        set_frame(8'h60, 24'h006000, -1, 1'b1);
        @(negedge clk) data_ready = 1'b0;
        pulse_dr();
        repeat (12) @(negedge clk);
        check("t5_queue", 44'(exp_q.size()), 44'd0);

        // Reset mid-frame with five words queued and an overrun pending.
        out_ready = 1'b0;
        set_frame(8'h70, 24'h007000, -1, 1'b0);
        @(negedge clk) data_ready = 1'b1;
        @(negedge clk) data_ready = 1'b0;
        @(negedge clk) data_ready = 1'b1;
        @(negedge clk) data_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("t6_pre_valid",   44'(out_valid),     44'd1);
        check("t6_pre_overrun", 44'(frame_overrun), 44'd1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid",    44'(out_valid),     44'd0);
        check("t6_rst_overrun",  44'(frame_overrun), 44'd0);
        check("t6_rst_overflow", 44'(fifo_overflow), 44'd0);
        check("t6_rst_dropped",  44'(dropped_count), 44'd0);
        @(negedge clk) rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        set_frame(8'h90, 24'h009000, -1, 1'b1);
        pulse_dr();
        repeat (12) @(negedge clk);
        check("t6_queue", 44'(exp_q.size()), 44'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
